pmem_loader: RTL
================

Name: pmem_loader

Overview:
Boot-time program loader that sits directly upstream of the swt16 core top level. It receives a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words. It writes those words into program memory through a dedicated write port and holds the core in reset until the image is loaded and its checksum verifies. Afterwards it releases the core and idles until a restart request.

Parameters:
PMEM_ADDR_WIDTH, 12, width of the pmem byte address.
PMEM_WORD_WIDTH, 16, instruction word width; fixed at 2 bytes per word.
PMEM_NUM_WORDS, 2048, capacity of pmem in words; longer images are rejected.
PC_INCREMENT, 2, address step per word; matches the fetch stage.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
in_byte  input  8  stream data byte.
in_byte_valid  input  1  in_byte is valid.
out_byte_ready  output  1  loader accepts a byte this cycle.
in_restart  input  1  single-cycle request to reload; honoured only in RUN or ERROR.
out_pmem_wr_en  output  1  pmem write strobe, one cycle per word.
out_pmem_wr_addr  output  PMEM_ADDR_WIDTH  pmem byte address.
out_pmem_wr_word  output  PMEM_WORD_WIDTH  word to write.
out_core_reset  output  1  active-low reset to the core; low holds the core in reset.
out_done  output  1  high in RUN.
out_error  output  1  high in ERROR.

Behaviour:
- Reset (async assert, sync release of state) sets:
  - state=LEN_LO, out_core_reset=0, out_pmem_wr_en=0, out_pmem_wr_addr=0, out_pmem_wr_word=0;
  - out_done=0, out_error=0, word count=0, index=0, checksum accumulator=0.
- Handshake: a byte transfers on a rising edge with in_byte_valid && out_byte_ready.
  - out_byte_ready=1 in LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM_LO, CSUM_HI.
  - out_byte_ready=0 in RUN and ERROR.
  - in_byte_valid low stalls any receive state indefinitely with no side effects.
- Frame format, little-endian 16-bit fields: length N (words), then N data words, then checksum = XOR of all N data words (0 when N=0).
- FSM transitions:
  - LEN_LO -> LEN_HI on transfer; latch low byte.
  - LEN_HI -> on transfer, form N:
    - N > PMEM_NUM_WORDS -> ERROR;
    - N == 0 -> CSUM_LO;
    - otherwise -> DATA_LO, with index=0 and accumulator=0.
  - DATA_LO -> DATA_HI on transfer; latch low byte.
  - DATA_HI -> on transfer, register a write issued the next cycle:
    - out_pmem_wr_en=1, out_pmem_wr_word={hi,lo}, out_pmem_wr_addr=index*PC_INCREMENT (truncated to PMEM_ADDR_WIDTH);
    - accumulator ^= word, index += 1;
    - next state: index+1 == N -> CSUM_LO, else DATA_LO.
  - out_pmem_wr_en is a single-cycle pulse, deasserted the following cycle. Back-to-back words yield writes at least 2 cycles apart.
  - CSUM_LO -> CSUM_HI on transfer.
  - CSUM_HI -> on transfer, compare {hi,lo} against the accumulator, where the accumulator already includes the final word:
    - equal -> RUN, with out_core_reset=1 registered on the same edge;
    - not equal -> ERROR.
  - RUN: out_done=1, out_core_reset=1. in_restart -> LEN_LO, out_core_reset=0 next cycle, out_done=0.
  - ERROR: out_error=1, out_core_reset=0. in_restart -> LEN_LO and clears out_error.
- in_restart has no effect in receive states. pmem contents are never cleared; stale words above the new image remain.
- Index counter width is clog2(PMEM_NUM_WORDS)+1 so that N=PMEM_NUM_WORDS is legal: last address = (PMEM_NUM_WORDS-1)*PC_INCREMENT.
- Reset asserted mid-load aborts immediately: core held in reset, no further writes, and the load restarts at LEN_LO.

Decomposition:
- Shared package swt16_pkg:
  - loader state enum (LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM_LO, CSUM_HI, RUN, ERROR);
  - BYTES_PER_WORD=2.
- One natural sub-module, byte_pair_assembler: latches the low byte, emits a 16-bit word plus a one-cycle word_valid on the high-byte transfer. It is reused for the length, data and checksum fields.

Test Plan:
- Load N=3, words 0x1234, 0xABCD, 0x0F0F, checksum 0xB6F6 -> writes (addr 0x000, 0x1234), (0x002, 0xABCD), (0x004, 0x0F0F); then out_done=1 and out_core_reset=1 one cycle after the last byte.
- Same image with checksum 0xB6F7 -> three writes occur, out_error=1, out_core_reset stays 0, out_byte_ready=0; in_restart -> LEN_LO with out_error=0.
- N=0 with checksum 0x0000 -> no writes, RUN; N=0x0801 -> ERROR after the length high byte, no writes.
- Random in_byte_valid gaps (valid held low 0-5 cycles) on the 3-word image -> identical writes and final state; no writes during stalls.
- Reset pulsed after the second data word -> all outputs at reset values asynchronously; a subsequent full load of the 3-word image succeeds.
- In RUN, in_restart pulse -> out_core_reset=0 and out_done=0 next cycle; reload of N=1 word 0xFFFF with checksum 0xFFFF -> write at addr 0x000, RUN again.

Source files
------------

// File: rtl/swt16_pkg.sv
// Shared definitions for the swt16 boot loader: FSM state encoding and word framing.
package swt16_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        CSUM_LO,
        CSUM_HI,
        RUN,
        ERROR
    } loader_state_e;

    localparam int BYTES_PER_WORD = 2;

endpackage

// File: rtl/byte_pair_assembler.sv
// Latches a low byte and presents {high, low} as a word during the high-byte transfer cycle.
module byte_pair_assembler
    import swt16_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic [7:0]                  data,
    input  logic                        take_lo,
    input  logic                        take_hi,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        word_valid
);

    logic [7:0] lo_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lo_q <= '0;
        end else if (take_lo) begin
            lo_q <= data;
        end
    end

    // Word is combinational so the FSM can act on the same edge as the high byte.
    assign word       = {data, lo_q};
    assign word_valid = take_hi;

endmodule

// File: rtl/pmem_loader.sv
// Boot loader: receives a length/data/checksum byte frame, writes pmem, and gates the core reset.
module pmem_loader
    import swt16_pkg::*;
#(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int PMEM_NUM_WORDS  = 2048,
    parameter int PC_INCREMENT    = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 in_byte,
    input  logic                       in_byte_valid,
    output logic                       out_byte_ready,
    input  logic                       in_restart,
    output logic                       out_pmem_wr_en,
    output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_wr_addr,
    output logic [PMEM_WORD_WIDTH-1:0] out_pmem_wr_word,
    output logic                       out_core_reset,
    output logic                       out_done,
    output logic                       out_error,
    output loader_state_e              dbg_state
);

    localparam int IDX_W  = $clog2(PMEM_NUM_WORDS) + 1;
    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam logic [WORD_W-1:0] MAX_LEN = WORD_W'(PMEM_NUM_WORDS);

    loader_state_e      state;
    logic [WORD_W-1:0]  len_q;
    logic [IDX_W-1:0]   index;
    logic [IDX_W-1:0]   index_next;
    logic [WORD_W-1:0]  acc;
    logic [31:0]        addr_full;

    logic               xfer;
    logic               take_lo;
    logic               take_hi;
    logic [WORD_W-1:0]  pair_word;
    logic               pair_valid;

    // Valid/ready: a byte moves on a rising edge where in_byte_valid && out_byte_ready.
    // Ready is a pure decode of the state register: high in every receive state.
    assign out_byte_ready = (state != RUN) && (state != ERROR);
    assign xfer           = in_byte_valid && out_byte_ready;
    assign take_lo        = xfer && (state == LEN_LO || state == DATA_LO || state == CSUM_LO);
    assign take_hi        = xfer && (state == LEN_HI || state == DATA_HI || state == CSUM_HI);
    assign index_next     = index + IDX_W'(1);
    assign addr_full      = 32'(index) * 32'(PC_INCREMENT);
    assign dbg_state      = state;

    byte_pair_assembler u_pair (
        .clock      (clock),
        .reset      (reset),
        .data       (in_byte),
        .take_lo    (take_lo),
        .take_hi    (take_hi),
        .word       (pair_word),
        .word_valid (pair_valid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= LEN_LO;
            len_q            <= '0;
            index            <= '0;
            acc              <= '0;
            out_pmem_wr_en   <= 1'b0;
            out_pmem_wr_addr <= '0;
            out_pmem_wr_word <= '0;
            out_core_reset   <= 1'b0;
            out_done         <= 1'b0;
            out_error        <= 1'b0;
        end else begin
            out_pmem_wr_en <= 1'b0;
            case (state)
                LEN_LO: if (xfer) state <= LEN_HI;
                LEN_HI: begin
                    if (pair_valid) begin
                        len_q <= pair_word;
                        index <= '0;
                        acc   <= '0;
                        if (pair_word > MAX_LEN) begin
                            state     <= ERROR;
                            out_error <= 1'b1;
                        end else if (pair_word == '0) begin
                            state <= CSUM_LO;
                        end else begin
                            state <= DATA_LO;
                        end
                    end
                end
                DATA_LO: if (xfer) state <= DATA_HI;
                DATA_HI: begin
                    if (pair_valid) begin
                        out_pmem_wr_en   <= 1'b1;
                        out_pmem_wr_word <= pair_word;
                        out_pmem_wr_addr <= PMEM_ADDR_WIDTH'(addr_full);
                        acc              <= acc ^ pair_word;
                        index            <= index_next;
                        state            <= (WORD_W'(index_next) == len_q) ? CSUM_LO : DATA_LO;
                    end
                end
                CSUM_LO: if (xfer) state <= CSUM_HI;
                CSUM_HI: begin
                    if (pair_valid) begin
                        if (pair_word == acc) begin
                            state          <= RUN;
                            out_core_reset <= 1'b1;
                            out_done       <= 1'b1;
                        end else begin
                            state     <= ERROR;
                            out_error <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_restart) begin
                        state          <= LEN_LO;
                        out_core_reset <= 1'b0;
                        out_done       <= 1'b0;
                    end
                end
                ERROR: begin
                    if (in_restart) begin
                        state     <= LEN_LO;
                        out_error <= 1'b0;
                    end
                end
                default: state <= LEN_LO;
            endcase
        end
    end

endmodule
